i2c_temp_slave: RTL and testbench

Behavioural I2C target modelling the temperature sensor addressed by the I2C master controller, placed directly downstream of the master on the shared SCL/SDA lines. It samples SCL/SDA with the system clock and detects START, repeated START and STOP. It decodes address, pointer and data bytes, drives ACK/NACK and read data through an open-drain enable, and holds a pointer register plus Config/Tlow/Thigh registers.

---
 rtl/i2c_temp_slave.sv | 276 +++++++++++++++++++++++++++
 tb/tb_i2c_temp_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_temp_slave.sv
// i2c_temp_slave
//   Behavioural I2C target modelling a temperature sensor. SCL/SDA are
//   sampled on Clk; START / repeated START / STOP are detected in every
//   state. The target decodes address, pointer and data bytes. It drives
//   ACK/NACK and read data through an open-drain enable, and holds a
//   pointer register plus the Config/Tlow/Thigh registers.
//
//   Optional build macro:
//     I2C_SLAVE_SYNC_EN - Scl/Sda_in pass through 2-flop synchronizers
//                         before edge detection (+2 Clk on every latency).
//
//   Ports:
//     Clk      in   system clock, bus lines sampled on rising edge
//     Rst      in   asynchronous active-low reset
//     Scl      in   bus clock from the master
//     Sda_in   in   resolved SDA line value
//     Temp     in   [15:0] live temperature word (pointer 00, read-only)
//     Sda_oe   out  1 = pull SDA low, 0 = release
//     Busy     out  high from address match until STOP
//     Pointer  out  [1:0] pointer register
//     Config   out  [7:0] configuration register (pointer 01)
//     Tlow     out  [15:0] low-limit register (pointer 10)
//     Thigh    out  [15:0] high-limit register (pointer 11)
//     Wr_done  out  one-Clk pulse when a register write commits
module i2c_temp_slave #(
  parameter logic [6:0]  DEV_ADDR  = 7'b1001000,
  parameter logic [15:0] TLOW_RST  = 16'h4B00,
  parameter logic [15:0] THIGH_RST = 16'h5000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Scl,
  input  logic        Sda_in,
  input  logic [15:0] Temp,
  output logic        Sda_oe,
  output logic        Busy,
  output logic [1:0]  Pointer,
  output logic [7:0]  Config,
  output logic [15:0] Tlow,
  output logic [15:0] Thigh,
  output logic        Wr_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_PTR,
    S_WR_MSB,
    S_WR_LSB,
    S_ACK,
    S_RD_MSB,
    S_RD_LSB,
    S_WAIT_STOP
  } state_t;

  logic        w_scl;
  logic        w_sda;

`ifdef I2C_SLAVE_SYNC_EN
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], Scl};
      r_sda_sync <= {r_sda_sync[0], Sda_in};
    end
  end

  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`else
  assign w_scl = Scl;
  assign w_sda = Sda_in;
`endif

  logic        r_scl_q;
  logic        r_sda_q;
  state_t      r_state;
  state_t      r_ack_next;
  logic [3:0]  r_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_shadow;
  logic [15:0] r_rd_word;

  logic        w_start;
  logic        w_stop;
  logic        w_rise;
  logic        w_fall;
  logic [15:0] w_sel_word;
  logic [7:0]  w_rd_byte;
  logic [2:0]  w_rd_idx;
  logic        w_rd_bit;

  // SDA must move while SCL is high in both samples; an SDA change that
  // coincides with an SCL rise is treated as data.
  assign w_start = r_scl_q & w_scl & r_sda_q & ~w_sda;
  assign w_stop  = r_scl_q & w_scl & ~r_sda_q & w_sda;
  assign w_rise  = ~r_scl_q & w_scl;
  assign w_fall  = r_scl_q & ~w_scl;

  always_comb begin
    w_sel_word = Temp;
    case (Pointer)
      2'b00:   w_sel_word = Temp;
      2'b01:   w_sel_word = {Config, 8'h00};
      2'b10:   w_sel_word = Tlow;
      default: w_sel_word = Thigh;
    endcase
  end

  assign w_rd_byte = (r_state == S_RD_LSB) ? r_rd_word[7:0] : r_rd_word[15:8];
  assign w_rd_idx  = 3'd7 - r_cnt[2:0];
  assign w_rd_bit  = w_rd_byte[w_rd_idx];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= S_IDLE;
      r_ack_next <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_shadow   <= '0;
      r_rd_word  <= '0;
      Sda_oe     <= 1'b0;
      Busy       <= 1'b0;
      Pointer    <= '0;
      Config     <= '0;
      Tlow       <= TLOW_RST;
      Thigh      <= THIGH_RST;
      Wr_done    <= 1'b0;
    end else begin
      Wr_done <= 1'b0;
      if (w_start) begin
        r_state <= S_ADDR;
        r_cnt   <= '0;
        Sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        Sda_oe  <= 1'b0;
        Busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            Sda_oe <= 1'b0;
          end

          // Receive path: shift on rises; the ACK decision is taken on
          // the fall that follows the 8th rise, using the complete byte.
          S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB: begin
            if (w_rise && (r_cnt != 4'd8)) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_fall && (r_cnt == 4'd8)) begin
              r_cnt <= '0;
              case (r_state)
                S_ADDR: begin
                  if (r_shift[7:1] == DEV_ADDR) begin
                    Sda_oe  <= 1'b1;
                    Busy    <= 1'b1;
                    r_state <= S_ACK;
                    if (r_shift[0]) begin
                      r_ack_next <= S_RD_MSB;
                      r_rd_word  <= w_sel_word;
                    end else begin
                      r_ack_next <= S_PTR;
                    end
                  end else begin
                    Busy    <= 1'b0;
                    r_state <= S_WAIT_STOP;
                  end
                end
                S_PTR: begin
                  if (r_shift[7:2] == 6'd0) begin
                    Sda_oe     <= 1'b1;
                    Pointer    <= r_shift[1:0];
                    r_state    <= S_ACK;
                    r_ack_next <= S_WR_MSB;
                  end else begin
                    r_state <= S_WAIT_STOP;
                  end
                end
                S_WR_MSB: begin
                  case (Pointer)
                    2'b00: begin
                      r_state <= S_WAIT_STOP;
                    end
                    2'b01: begin
                      Sda_oe     <= 1'b1;
                      Config     <= r_shift;
                      Wr_done    <= 1'b1;
                      r_state    <= S_ACK;
                      r_ack_next <= S_WAIT_STOP;
                    end
                    default: begin
                      Sda_oe     <= 1'b1;
                      r_shadow   <= r_shift;
                      r_state    <= S_ACK;
                      r_ack_next <= S_WR_LSB;
                    end
                  endcase
                end
                S_WR_LSB: begin
                  if (Pointer[1]) begin
                    if (Pointer[0]) Thigh <= {r_shadow, r_shift};
                    else            Tlow  <= {r_shadow, r_shift};
                    Sda_oe     <= 1'b1;
                    Wr_done    <= 1'b1;
                    r_state    <= S_ACK;
                    r_ack_next <= S_WAIT_STOP;
                  end else begin
                    r_state <= S_WAIT_STOP;
                  end
                end
                default: begin
                  r_state <= S_WAIT_STOP;
                end
              endcase
            end
          end

          // The fall that ends a read-address ACK also drives the first
          // data bit, so the read states see it already on the line.
          S_ACK: begin
            if (w_fall) begin
              r_state <= r_ack_next;
              r_cnt   <= '0;
              Sda_oe  <= (r_ack_next == S_RD_MSB) ? ~r_rd_word[15] : 1'b0;
            end
          end

          S_RD_MSB, S_RD_LSB: begin
            if (w_fall) begin
              Sda_oe <= (r_cnt < 4'd8) ? ~w_rd_bit : 1'b0;
            end else if (w_rise) begin
              if (r_cnt == 4'd8) begin
                r_cnt <= '0;
                if (!w_sda) begin
                  r_state <= (r_state == S_RD_MSB) ? S_RD_LSB : S_RD_MSB;
                end else begin
                  Sda_oe  <= 1'b0;
                  r_state <= S_WAIT_STOP;
                end
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end

          S_WAIT_STOP: begin
            Sda_oe <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
            Sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_temp_slave.sv
// Testbench for i2c_temp_slave: table-driven write transactions plus
// hand-written read, wrap-around and reset-during-read sequences.
module tb_i2c_temp_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        sda_m;
  logic [15:0] temp;
  logic        sda_line;
  logic        sda_oe;
  logic        busy;
  logic [1:0]  pointer;
  logic [7:0]  cfg;
  logic [15:0] tlow;
  logic [15:0] thigh;
  logic        wr_done;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_temp_slave #(
    .DEV_ADDR (7'b1001000),
    .TLOW_RST (16'h4B00),
    .THIGH_RST(16'h5000)
  ) dut (
    .Clk    (clk),
    .Rst    (rst_n),
    .Scl    (scl),
    .Sda_in (sda_line),
    .Temp   (temp),
    .Sda_oe (sda_oe),
    .Busy   (busy),
    .Pointer(pointer),
    .Config (cfg),
    .Tlow   (tlow),
    .Thigh  (thigh),
    .Wr_done(wr_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned wr_pulses = 0;
  int unsigned wr_hi     = 0;
  logic        wr_prev   = 1'b0;

  always @(negedge clk) begin
    if (wr_done) wr_hi <= wr_hi + 1;
    if (wr_done && !wr_prev) wr_pulses <= wr_pulses + 1;
    wr_prev <= wr_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within 1 ms");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  ptr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int unsigned nb;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_ptr;
    logic [7:0]  exp_cfg;
    logic [15:0] exp_tlow;
    logic [15:0] exp_thigh;
    int unsigned exp_wr;
    logic        chk_busy;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic wclk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    wclk(4);
    scl = 1'b1;
    wclk(5);
    s = sda_line;
    scl = 1'b0;
    wclk(4);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wclk(4);
    scl = 1'b1;
    wclk(4);
    sda_m = 1'b0;
    wclk(4);
    scl = 1'b0;
    wclk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wclk(4);
    scl = 1'b1;
    wclk(4);
    sda_m = 1'b1;
    wclk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ak);
    logic s;
    for (int unsigned i = 0; i < 8; i++) clk_bit(b[7-i], s);
    clk_bit(1'b1, s);
    ak = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int unsigned i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d[7-i] = s;
    end
    clk_bit(~mack, s);
  endtask

  task automatic xfer(input logic [7:0] a, input logic [7:0] p,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input int unsigned nb,
                      output logic [3:0] acks, output logic busy_pre);
    logic [7:0] b;
    logic       ak;
    acks = '0;
    bus_start();
    for (int unsigned i = 0; i < nb; i++) begin
      case (i)
        0:       b = a;
        1:       b = p;
        2:       b = d0;
        default: b = d1;
      endcase
      send_byte(b, ak);
      acks[i] = ak;
      if (!ak) break;
    end
    busy_pre = busy;
    bus_stop();
  endtask

  initial begin
    logic [3:0]  acks;
    logic        busy_pre;
    logic        ak;
    logic        s;
    logic [7:0]  d;
    logic [3:0]  bits4;
    int unsigned p0;
    int unsigned h0;

    vecs[0] = '{8'h90, 8'h02, 8'h12, 8'h34, 4, 4'b1111, 2'd2, 8'h00, 16'h1234, 16'h5000, 1, 1'b1, 1'b1};
    vecs[1] = '{8'h90, 8'h01, 8'hA5, 8'h00, 3, 4'b0111, 2'd1, 8'hA5, 16'h1234, 16'h5000, 1, 1'b1, 1'b1};
    vecs[2] = '{8'h90, 8'h01, 8'h3C, 8'h77, 4, 4'b0111, 2'd1, 8'h3C, 16'h1234, 16'h5000, 1, 1'b0, 1'b0};
    vecs[3] = '{8'h90, 8'h03, 8'h55, 8'h00, 3, 4'b0111, 2'd3, 8'h3C, 16'h1234, 16'h5000, 0, 1'b1, 1'b1};
    vecs[4] = '{8'h90, 8'h03, 8'h56, 8'h78, 4, 4'b1111, 2'd3, 8'h3C, 16'h1234, 16'h5678, 1, 1'b1, 1'b1};
    vecs[5] = '{8'h90, 8'h05, 8'h00, 8'h00, 2, 4'b0001, 2'd3, 8'h3C, 16'h1234, 16'h5678, 0, 1'b0, 1'b0};
    vecs[6] = '{8'h90, 8'h00, 8'hAA, 8'h00, 3, 4'b0011, 2'd0, 8'h3C, 16'h1234, 16'h5678, 0, 1'b0, 1'b0};
    vecs[7] = '{8'h92, 8'h02, 8'h11, 8'h22, 4, 4'b0000, 2'd0, 8'h3C, 16'h1234, 16'h5678, 0, 1'b1, 1'b0};
    vecs[8] = '{8'h90, 8'h02, 8'h00, 8'h00, 2, 4'b0011, 2'd2, 8'h3C, 16'h1234, 16'h5678, 0, 1'b1, 1'b1};

    temp  = 16'h1900;
    scl   = 1'b1;
    sda_m = 1'b1;
    rst_n = 1'b0;
    wclk(3);
    chk("rst_sda_oe",  {31'd0, sda_oe},  32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_pointer", {30'd0, pointer}, 32'd0);
    chk("rst_config",  {24'd0, cfg},     32'h00);
    chk("rst_tlow",    {16'd0, tlow},    32'h4B00);
    chk("rst_thigh",   {16'd0, thigh},   32'h5000);
    chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
    rst_n = 1'b1;
    wclk(4);

    for (int unsigned v = 0; v < 9; v++) begin
      p0 = wr_pulses;
      h0 = wr_hi;
      xfer(vecs[v].addr, vecs[v].ptr, vecs[v].d0, vecs[v].d1, vecs[v].nb, acks, busy_pre);
      wclk(2);
      chk($sformatf("v%0d_acks", v),    {28'd0, acks},    {28'd0, vecs[v].exp_ack});
      chk($sformatf("v%0d_pointer", v), {30'd0, pointer}, {30'd0, vecs[v].exp_ptr});
      chk($sformatf("v%0d_config", v),  {24'd0, cfg},     {24'd0, vecs[v].exp_cfg});
      chk($sformatf("v%0d_tlow", v),    {16'd0, tlow},    {16'd0, vecs[v].exp_tlow});
      chk($sformatf("v%0d_thigh", v),   {16'd0, thigh},   {16'd0, vecs[v].exp_thigh});
      chk($sformatf("v%0d_wr_pulses", v), wr_pulses - p0, vecs[v].exp_wr);
      chk($sformatf("v%0d_wr_cycles", v), wr_hi - h0,     vecs[v].exp_wr);
      chk($sformatf("v%0d_busy_after_stop", v), {31'd0, busy}, 32'd0);
      if (vecs[v].chk_busy)
        chk($sformatf("v%0d_busy_before_stop", v), {31'd0, busy_pre}, {31'd0, vecs[v].exp_busy});
    end

    // Read Temp through a repeated START.
    bus_start();
    send_byte(8'h90, ak);
    chk("rt_addr_w_ack", {31'd0, ak}, 32'd1);
    send_byte(8'h00, ak);
    chk("rt_ptr_ack", {31'd0, ak}, 32'd1);
    bus_start();
    send_byte(8'h91, ak);
    chk("rt_addr_r_ack", {31'd0, ak}, 32'd1);
    chk("rt_busy", {31'd0, busy}, 32'd1);
    read_byte(1'b1, d);
    chk("rt_msb", {24'd0, d}, 32'h19);
    read_byte(1'b0, d);
    chk("rt_lsb", {24'd0, d}, 32'h00);
    chk("rt_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    read_byte(1'b0, d);
    chk("rt_wait_stop_released", {24'd0, d}, 32'hFF);
    bus_stop();
    wclk(2);
    chk("rt_busy_after_stop", {31'd0, busy}, 32'd0);

    // Read Thigh with master ACK after LSB: the same word wraps.
    bus_start();
    send_byte(8'h90, ak);
    send_byte(8'h03, ak);
    bus_start();
    send_byte(8'h91, ak);
    chk("wrap_addr_ack", {31'd0, ak}, 32'd1);
    read_byte(1'b1, d);
    chk("wrap_b0", {24'd0, d}, 32'h56);
    read_byte(1'b1, d);
    chk("wrap_b1", {24'd0, d}, 32'h78);
    read_byte(1'b0, d);
    chk("wrap_b2", {24'd0, d}, 32'h56);
    bus_stop();

    // Reset while the slave drives bit 3 of the Thigh MSB (0x56, bit3=0).
    tlow_before_reset_check: begin
      bus_start();
      send_byte(8'h90, ak);
      send_byte(8'h03, ak);
      bus_start();
      send_byte(8'h91, ak);
      for (int unsigned i = 0; i < 4; i++) begin
        clk_bit(1'b1, s);
        bits4[3-i] = s;
      end
      chk("rr_bits7to4", {28'd0, bits4}, 32'h5);
      chk("rr_oe_bit3", {31'd0, sda_oe}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rr_oe_in_reset",  {31'd0, sda_oe},  32'd0);
      chk("rr_ptr_in_reset", {30'd0, pointer}, 32'd0);
      chk("rr_tlow_in_reset", {16'd0, tlow},   32'h4B00);
      chk("rr_thigh_in_reset", {16'd0, thigh}, 32'h5000);
      chk("rr_cfg_in_reset", {24'd0, cfg},     32'h00);
      chk("rr_busy_in_reset", {31'd0, busy},   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      scl   = 1'b1;
      sda_m = 1'b1;
      wclk(4);
    end

    p0 = wr_pulses;
    xfer(8'h90, 8'h02, 8'hAB, 8'hCD, 4, acks, busy_pre);
    wclk(2);
    chk("post_rst_acks", {28'd0, acks}, 32'hF);
    chk("post_rst_tlow", {16'd0, tlow}, 32'hABCD);
    chk("post_rst_thigh", {16'd0, thigh}, 32'h5000);
    chk("post_rst_wr", wr_pulses - p0, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
